// File: rtl/rom_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rom_rr_arbiter
//
// Round-robin read arbiter that shares one synchronous single-port ROM
// (one-cycle read latency) between N requesters. On each clock it grants at
// most one pending requester and drives that requester's address to the ROM.
// Two cycles later it steers the returned word back with a one-hot valid
// pulse.
//
// Parameters
//   N   number of requesters (2..8)
//   AW  ROM address width
//   DW  ROM data width
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous, active-high reset
//   req       in   [N]     per-requester read request, held until granted
//   addr      in   [N*AW]  flattened addresses, requester i at [i*AW +: AW]
//   gnt       out  [N]     registered one-hot grant, one-cycle pulse
//   rvalid    out  [N]     one-hot read-data valid, two cycles after grant edge
//   rdata     out  [DW]    read data, meaningful only with an rvalid bit set
//   rom_en    out          ROM read enable, high during the grant cycle
//   rom_addr  out  [AW]    ROM address, registered together with gnt
//   rom_data  in   [DW]    ROM output, valid the cycle after rom_en
// ---------------------------------------------------------------------------
module rom_rr_arbiter #(
    parameter int N  = 4,
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rvalid,
    output logic [DW-1:0]   rdata,
    output logic            rom_en,
    output logic [AW-1:0]   rom_addr,
    input  logic [DW-1:0]   rom_data
);

    localparam int PW = $clog2(N);

    // Round-robin pointer: index of the most recent winner.
    logic [PW-1:0] ptr;

    // Request tag travelling alongside the ROM access (grant cycle).
    logic          tag_v;
    logic [PW-1:0] tag;

    // Return stage: aligned with rom_data one cycle after the grant cycle.
    logic          ret_v;
    logic [PW-1:0] ret_idx;

    // Arbitration results.
    logic [N-1:0]  eligible;
    logic          found;
    logic [PW-1:0] win;

    // The requester currently holding gnt is masked so that a held req is
    // seen as a fresh request only from the edge after its grant cycle.
    // NOTE: every signal assigned in always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        eligible = req & ~gnt;
        found    = 1'b0;
        win      = '0;
        // Search order ptr+1, ptr+2, ... wrapping modulo N; first hit wins.
        for (int k = 1; k <= N; k++) begin
            if (!found && eligible[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % N);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            ptr      <= PW'(N - 1);   // requester 0 searched first after reset
            tag_v    <= 1'b0;
            tag      <= '0;
            ret_v    <= 1'b0;
            ret_idx  <= '0;
        end else begin
            if (found) begin
                gnt      <= N'(1) << win;
                rom_en   <= 1'b1;
                rom_addr <= addr[int'(win)*AW +: AW];
                ptr      <= win;
                tag_v    <= 1'b1;
                tag      <= win;
            end else begin
                // Idle: rom_addr and ptr hold their values.
                gnt      <= '0;
                rom_en   <= 1'b0;
                tag_v    <= 1'b0;
            end
            ret_v   <= tag_v;
            ret_idx <= tag;
        end
    end

    // Data passes straight through; clients qualify it with their rvalid bit.
    assign rvalid = ret_v ? (N'(1) << ret_idx) : '0;
    assign rdata  = rom_data;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_rr_arbiter
//
// Directed bench for rom_rr_arbiter with N=4, AW=4, DW=4. A local ROM model
// holds mem[i] = i and registers its output one cycle after rom_en. Inputs
// change 1 time unit after a rising edge; outputs are sampled at the same
// point, i.e. in the cycle that follows the edge just taken.
// ---------------------------------------------------------------------------
module tb_rom_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            rom_en;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;

    logic [DW-1:0]   mem [2**AW];

    int n_cmp = 0;
    int n_err = 0;

    rom_rr_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Take one rising edge and settle just after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] eg, input logic [N-1:0] erv,
                       input logic een);
        check({tag, ".gnt"},    32'(gnt),    32'(eg));
        check({tag, ".rvalid"}, 32'(rvalid), 32'(erv));
        check({tag, ".rom_en"}, 32'(rom_en), 32'(een));
    endtask

    task automatic chk_addr(input string tag, input logic [AW-1:0] ea);
        check({tag, ".rom_addr"}, 32'(rom_addr), 32'(ea));
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] ed);
        check({tag, ".rdata"}, 32'(rdata), 32'(ed));
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
        rst  = 1'b1;
        req  = '0;
        addr = '0;

        // ---- Reset state ----
        cycle();
        cycle();
        chk("reset", 4'b0000, 4'b0000, 1'b0);
        chk_addr("reset", 4'd0);
        rst = 1'b0;

        // ---- Idle for 10 cycles ----
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk($sformatf("idle%0d", i), 4'b0000, 4'b0000, 1'b0);
            chk_addr($sformatf("idle%0d", i), 4'd0);
        end

        // ---- Single request: requester 0, address 5 ----
        req  = 4'b0001;
        addr = 16'h0005;
        cycle();
        chk("single.c1", 4'b0001, 4'b0000, 1'b1);
        chk_addr("single.c1", 4'd5);
        req = 4'b0000;
        cycle();
        chk("single.c2", 4'b0000, 4'b0001, 1'b0);
        chk_data("single.c2", 4'd5);
        cycle();
        chk("single.c3", 4'b0000, 4'b0000, 1'b0);

        // ---- Re-reset, then all four request at once (3,7,9,12) ----
        rst = 1'b1;
        cycle();
        chk("rerst", 4'b0000, 4'b0000, 1'b0);
        chk_addr("rerst", 4'd0);
        rst  = 1'b0;
        req  = 4'b1111;
        addr = 16'hC973;
        cycle();
        chk("all.c1", 4'b0001, 4'b0000, 1'b1);
        chk_addr("all.c1", 4'd3);
        req = 4'b1110;
        cycle();
        chk("all.c2", 4'b0010, 4'b0001, 1'b1);
        chk_addr("all.c2", 4'd7);
        chk_data("all.c2", 4'd3);
        req = 4'b1100;
        cycle();
        chk("all.c3", 4'b0100, 4'b0010, 1'b1);
        chk_addr("all.c3", 4'd9);
        chk_data("all.c3", 4'd7);
        req = 4'b1000;
        cycle();
        chk("all.c4", 4'b1000, 4'b0100, 1'b1);
        chk_addr("all.c4", 4'd12);
        chk_data("all.c4", 4'd9);
        req = 4'b0000;
        cycle();
        chk("all.c5", 4'b0000, 4'b1000, 1'b0);
        chk_data("all.c5", 4'd12);
        cycle();
        chk("all.c6", 4'b0000, 4'b0000, 1'b0);

        // ---- Fairness: req0 (addr 10) and req2 (addr 6) held; ptr = 3 ----
        req  = 4'b0101;
        addr = 16'h060A;
        cycle();
        chk("fair.c1", 4'b0001, 4'b0000, 1'b1);
        chk_addr("fair.c1", 4'd10);
        cycle();
        chk("fair.c2", 4'b0100, 4'b0001, 1'b1);
        chk_addr("fair.c2", 4'd6);
        chk_data("fair.c2", 4'd10);
        cycle();
        chk("fair.c3", 4'b0001, 4'b0100, 1'b1);
        chk_data("fair.c3", 4'd6);
        cycle();
        chk("fair.c4", 4'b0100, 4'b0001, 1'b1);
        chk_data("fair.c4", 4'd10);
        req = 4'b0000;
        cycle();
        chk("fair.c5", 4'b0000, 4'b0100, 1'b0);
        chk_data("fair.c5", 4'd6);
        cycle();
        chk("fair.c6", 4'b0000, 4'b0000, 1'b0);

        // ---- Back-to-back: req1 held, address 1,2,3; ptr = 2 ----
        req  = 4'b0010;
        addr = 16'h0010;
        cycle();
        chk("b2b.c1", 4'b0010, 4'b0000, 1'b1);
        chk_addr("b2b.c1", 4'd1);
        addr = 16'h0020;
        cycle();
        chk("b2b.c2", 4'b0000, 4'b0010, 1'b0);
        chk_addr("b2b.c2", 4'd1);
        chk_data("b2b.c2", 4'd1);
        cycle();
        chk("b2b.c3", 4'b0010, 4'b0000, 1'b1);
        chk_addr("b2b.c3", 4'd2);
        addr = 16'h0030;
        cycle();
        chk("b2b.c4", 4'b0000, 4'b0010, 1'b0);
        chk_data("b2b.c4", 4'd2);
        cycle();
        chk("b2b.c5", 4'b0010, 4'b0000, 1'b1);
        chk_addr("b2b.c5", 4'd3);
        req = 4'b0000;
        cycle();
        chk("b2b.c6", 4'b0000, 4'b0010, 1'b0);
        chk_data("b2b.c6", 4'd3);
        cycle();
        chk("b2b.c7", 4'b0000, 4'b0000, 1'b0);

        // ---- Reset mid-flight: all four held; ptr = 1 ----
        req  = 4'b1111;
        addr = 16'hC973;
        cycle();
        chk("midrst.c1", 4'b0100, 4'b0000, 1'b1);
        chk_addr("midrst.c1", 4'd9);
        cycle();
        chk("midrst.c2", 4'b1000, 4'b0100, 1'b1);
        chk_addr("midrst.c2", 4'd12);
        chk_data("midrst.c2", 4'd9);
        rst = 1'b1;
        cycle();
        chk("midrst.c3", 4'b0000, 4'b0000, 1'b0);
        chk_addr("midrst.c3", 4'd0);
        rst = 1'b0;
        cycle();
        chk("midrst.c4", 4'b0001, 4'b0000, 1'b1);
        chk_addr("midrst.c4", 4'd3);
        cycle();
        chk("midrst.c5", 4'b0010, 4'b0001, 1'b1);
        chk_addr("midrst.c5", 4'd7);
        chk_data("midrst.c5", 4'd3);
        req = 4'b0000;
        cycle();
        chk("midrst.c6", 4'b0000, 4'b0010, 1'b0);
        chk_data("midrst.c6", 4'd7);
        cycle();
        chk("midrst.c7", 4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_rr_arbiter.md
# rom_rr_arbiter

Round-robin read arbiter that shares one synchronous single-port ROM (AW-bit address, DW-bit data, one-cycle read latency) between N requesters. Each cycle it picks at most one pending requester, drives the ROM address and enable, and routes the returned word back to the winner with a per-requester valid pulse. It sits between the ROM instance in the memory subsystem and the client blocks that fetch constants or microcode from it.

## Interface
- N, 4, number of requesters (2..8)
- AW, 4, ROM address width (depth = 2**AW)
- DW, 4, ROM data width
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N  request per requester; held high with stable address until granted
- addr  in  N*AW  flattened request addresses; requester i uses bits [i*AW +: AW]
- gnt  out  N  registered one-hot grant, one-cycle pulse
- rvalid  out  N  one-hot read-data valid, one-cycle pulse, two cycles after grant edge
- rdata  out  DW  read data, meaningful only when some rvalid bit is high
- rom_en  out  1  ROM read enable, high in the cycle a grant is active
- rom_addr  out  AW  ROM address, registered together with gnt
- rom_data  in  DW  ROM output, registered inside ROM, valid the cycle after rom_en

## Operation
- Eligible set at each edge: req & ~gnt (requester currently granted is masked for that edge).
- Round-robin pointer ptr (log2 N bits) holds last winner; search order ptr+1, ptr+2, ... wrapping modulo N; first eligible wins.
- On winner w: gnt <= onehot(w), rom_addr <= addr[w], rom_en <= 1, ptr <= w, tag_v <= 1, tag <= w.
- No eligible requester: gnt <= 0, rom_en <= 0, rom_addr holds, ptr holds, tag_v <= 0.
- Return stage: one pipeline register pair (ret_v, ret_idx) loaded from (tag_v, tag) each edge; rvalid = ret_v ? onehot(ret_idx) : 0; rdata = rom_data (passthrough).
- rdata not qualified otherwise; clients sample only on their rvalid bit.
- Requester protocol: keep req and addr stable until gnt seen; may drop req or present a new address on the edge ending the gnt cycle. A req still high at that edge is treated as a new request (eligible from the following edge).
- Non-pending requesters never receive gnt or rvalid; at most one gnt bit and one rvalid bit high per cycle.

## Timing
- Reset: gnt=0, rvalid=0, rom_en=0, rom_addr=0, ptr=N-1 (requester 0 highest priority first), tag_v=0, ret_v=0.
- Latency: req sampled at edge E -> gnt/rom_en/rom_addr in cycle E+1 -> ROM captures at edge E+1 -> rom_data and rvalid in cycle E+2. Request-to-data = 2 cycles minimum.
- Throughput: one grant per cycle when requests come from different requesters; a single requester holding req continuously is granted every other cycle.
- Starvation bound: any held request is granted within N cycles.
- Simultaneous requests from all N: grants in consecutive cycles in round-robin order from ptr+1.
- Reset asserted mid-operation: at that edge all outputs return to reset values; in-flight reads discarded (no rvalid even though ROM still produces data); ptr returns to N-1.
- Reset deasserted: first arbitration at the first edge with rst low.
- rdata value outside rvalid cycles is don't-care.

## Test plan
- Bench ROM model mem[i]=i, N=4, AW=4, DW=4. Single request: req=0001, addr0=5 at edge 0 -> gnt=0001, rom_addr=5, rom_en=1 in cycle 1; rvalid=0001, rdata=5 in cycle 2; nothing after req drops.
- All four request at once (addrs 3,7,9,12), each dropped after its gnt -> gnt 0001,0010,0100,1000 in cycles 1..4; rvalid same order in cycles 2..5 with rdata 3,7,9,12.
- Fairness: req0 and req2 held high continuously -> grants alternate 0,2,0,2 in consecutive cycles; neither waits more than 2 cycles.
- Same requester back-to-back: req1 held with addr changed after each gnt (1,2,3) -> gnt1 in cycles 1,3,5; rdata 1,2,3 in cycles 2,4,6; no gnt in cycles 2,4.
- Reset mid-flight: 4 requests outstanding, rst high in cycle 2 for one cycle -> cycle 3 all gnt/rvalid/rom_en 0; after release, held requests regranted starting with requester 0.
- Idle: req=0 for 10 cycles after reset -> gnt, rvalid, rom_en stay 0; rom_addr stays 0.
